// File: rtl/calc_pkg.sv
// rtl/calc_pkg.sv - shared key codes, op codes and entry state encoding for the calculator stages
package calc_pkg;

  localparam logic [3:0] KEY_DIGIT_MAX = 4'd9;
  localparam logic [3:0] KEY_ADD       = 4'd10;
  localparam logic [3:0] KEY_SUB       = 4'd11;
  localparam logic [3:0] KEY_MUL       = 4'd12;
  localparam logic [3:0] KEY_DIV       = 4'd13;
  localparam logic [3:0] KEY_EQ        = 4'd14;
  localparam logic [3:0] KEY_CLR       = 4'd15;

  localparam logic [1:0] OP_ADD = 2'd0;
  localparam logic [1:0] OP_SUB = 2'd1;
  localparam logic [1:0] OP_MUL = 2'd2;
  localparam logic [1:0] OP_DIV = 2'd3;

  localparam logic [1:0] ST_ENT_A = 2'd0;
  localparam logic [1:0] ST_OPR   = 2'd1;
  localparam logic [1:0] ST_ENT_B = 2'd2;
  localparam logic [1:0] ST_ISSUE = 2'd3;

  typedef struct packed {
    logic [3:0] tens;
    logic [3:0] ones;
  } digits_t;

  function automatic logic is_digit(input logic [3:0] key);
    return key <= KEY_DIGIT_MAX;
  endfunction

  function automatic logic is_oper(input logic [3:0] key);
    return (key >= KEY_ADD) && (key <= KEY_DIV);
  endfunction

  // Operator keys are contiguous, so the op code is the offset from '+'.
  function automatic logic [1:0] op_from_key(input logic [3:0] key);
    logic [3:0] w_off;
    w_off = key - KEY_ADD;
    return w_off[1:0];
  endfunction

endpackage

// File: rtl/calc_entry_if.sv
// rtl/calc_entry_if.sv - key input, request output and display bundle of the entry stage
interface calc_entry_if;
  logic       key_valid;
  logic [3:0] key_code;
  logic       key_ready;
  logic [7:0] op_a;
  logic [7:0] op_b;
  logic [1:0] op_code;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] disp_tens;
  logic [3:0] disp_ones;
  logic       err;

  modport master (
    output key_valid, key_code, out_ready,
    input  key_ready, op_a, op_b, op_code, out_valid, disp_tens, disp_ones, err
  );

  modport slave (
    input  key_valid, key_code, out_ready,
    output key_ready, op_a, op_b, op_code, out_valid, disp_tens, disp_ones, err
  );
endinterface

// File: rtl/calc_digit_pair.sv
// rtl/calc_digit_pair.sv - two-digit decimal shift register with count, clear and joined value
module calc_digit_pair (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_clear,
  input  logic       i_shift,
  input  logic [3:0] i_digit,
  output logic [3:0] o_tens,
  output logic [3:0] o_ones,
  output logic [1:0] o_count,
  output logic [7:0] o_value
);

  logic [3:0] r_tens;
  logic [3:0] r_ones;
  logic [1:0] r_count;

  // The caller owns the two-digit limit; clear wins over a same-cycle shift.
  always_ff @(posedge clk) begin
    if (rst || i_clear) begin
      r_tens  <= 4'd0;
      r_ones  <= 4'd0;
      r_count <= 2'd0;
    end else if (i_shift) begin
      r_tens  <= r_ones;
      r_ones  <= i_digit;
      r_count <= r_count + 2'd1;
    end
  end

  assign o_tens  = r_tens;
  assign o_ones  = r_ones;
  assign o_count = r_count;
  assign o_value = ({4'd0, r_tens} * 8'd10) + {4'd0, r_ones};

endmodule

// File: rtl/calc_entry.sv
// rtl/calc_entry.sv - keypad entry FSM building two operands and an operator into one request
module calc_entry
  import calc_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  calc_entry_if.slave  bus
);

  logic [1:0] r_state;
  logic [7:0] r_op_a;
  logic [7:0] r_op_b;
  logic [1:0] r_op_code;
  logic       r_err;

  logic       w_key_ready;
  logic       w_accept;
  logic       w_digit;
  logic       w_oper;
  logic       w_eq;
  logic       w_clr;
  logic       w_a_shift, w_a_clear, w_b_shift, w_b_clear;
  logic [3:0] w_a_tens, w_a_ones, w_b_tens, w_b_ones;
  logic [1:0] w_a_count, w_b_count;
  logic [7:0] w_a_value, w_b_value;
  logic [1:0] w_state_nxt;
  logic [1:0] w_op_code_nxt;
  logic       w_latch;
  logic       w_err_nxt;

  assign w_key_ready = (r_state != ST_ISSUE);
  assign w_accept    = bus.key_valid && w_key_ready;
  assign w_digit     = w_accept && is_digit(bus.key_code);
  assign w_oper      = w_accept && is_oper(bus.key_code);
  assign w_eq        = w_accept && (bus.key_code == KEY_EQ);
  assign w_clr       = w_accept && (bus.key_code == KEY_CLR);

  calc_digit_pair u_pair_a (
    .clk     (clk),
    .rst     (rst),
    .i_clear (w_a_clear),
    .i_shift (w_a_shift),
    .i_digit (bus.key_code),
    .o_tens  (w_a_tens),
    .o_ones  (w_a_ones),
    .o_count (w_a_count),
    .o_value (w_a_value)
  );

  calc_digit_pair u_pair_b (
    .clk     (clk),
    .rst     (rst),
    .i_clear (w_b_clear),
    .i_shift (w_b_shift),
    .i_digit (bus.key_code),
    .o_tens  (w_b_tens),
    .o_ones  (w_b_ones),
    .o_count (w_b_count),
    .o_value (w_b_value)
  );

  always_comb begin
    w_state_nxt   = r_state;
    w_op_code_nxt = r_op_code;
    w_a_shift     = 1'b0;
    w_a_clear     = 1'b0;
    w_b_shift     = 1'b0;
    w_b_clear     = 1'b0;
    w_latch       = 1'b0;
    w_err_nxt     = 1'b0;
    if (w_clr) begin
      w_state_nxt   = ST_ENT_A;
      w_op_code_nxt = OP_ADD;
      w_a_clear     = 1'b1;
      w_b_clear     = 1'b1;
    end else begin
      case (r_state)
        ST_ENT_A: begin
          if (w_digit && (w_a_count < 2'd2)) begin
            w_a_shift = 1'b1;
          end else if (w_oper && (w_a_count != 2'd0)) begin
            w_op_code_nxt = op_from_key(bus.key_code);
            w_b_clear     = 1'b1;
            w_state_nxt   = ST_OPR;
          end
        end
        ST_OPR: begin
          if (w_oper) begin
            w_op_code_nxt = op_from_key(bus.key_code);
          end else if (w_digit) begin
            w_b_shift   = 1'b1;
            w_state_nxt = ST_ENT_B;
          end
        end
        ST_ENT_B: begin
          if (w_digit && (w_b_count < 2'd2)) begin
            w_b_shift = 1'b1;
          end else if (w_eq) begin
            // Divide-by-zero never reaches the arithmetic stage.
            if ((r_op_code == OP_DIV) && (w_b_value == 8'd0)) begin
              w_err_nxt   = 1'b1;
              w_a_clear   = 1'b1;
              w_b_clear   = 1'b1;
              w_state_nxt = ST_ENT_A;
            end else begin
              w_latch     = 1'b1;
              w_state_nxt = ST_ISSUE;
            end
          end
        end
        default: begin
          if (bus.out_ready) begin
            w_a_clear   = 1'b1;
            w_b_clear   = 1'b1;
            w_state_nxt = ST_ENT_A;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_ENT_A;
      r_op_a    <= 8'd0;
      r_op_b    <= 8'd0;
      r_op_code <= OP_ADD;
      r_err     <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_op_code <= w_op_code_nxt;
      r_err     <= w_err_nxt;
      if (w_latch) begin
        r_op_a <= w_a_value;
        r_op_b <= w_b_value;
      end
    end
  end

  // B keeps its digits until the handshake, so ISSUE shows the operand just sent.
  assign bus.key_ready = w_key_ready;
  assign bus.out_valid = (r_state == ST_ISSUE);
  assign bus.op_a      = r_op_a;
  assign bus.op_b      = r_op_b;
  assign bus.op_code   = r_op_code;
  assign bus.err       = r_err;
  assign bus.disp_tens = ((r_state == ST_ENT_B) || (r_state == ST_ISSUE)) ? w_b_tens : w_a_tens;
  assign bus.disp_ones = ((r_state == ST_ENT_B) || (r_state == ST_ISSUE)) ? w_b_ones : w_a_ones;

endmodule

// File: tb/tb_calc_entry.sv
// tb/tb_calc_entry.sv - directed and random keypad sequences checked against a behavioural calculator model
module tb_calc_entry;

  logic clk;
  logic rst;
  calc_entry_if bus ();

  calc_entry dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int    errors = 0;
  int    checks = 0;
  bit    g_rdy  = 1'b1;

  string m_mode;
  int    a_val, a_cnt, b_val, b_cnt, m_op, m_oa, m_ob;
  bit    m_err;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d (mode %s)", tag, obs, exp, m_mode);
    end
  endtask

  task automatic model_clear_operands();
    a_val = 0; a_cnt = 0; b_val = 0; b_cnt = 0;
  endtask

  task automatic model_edge(input bit v, input int k, input bit rdy, input bit r);
    m_err = 1'b0;
    if (r) begin
      model_clear_operands();
      m_mode = "A"; m_op = 0; m_oa = 0; m_ob = 0;
      return;
    end
    if (m_mode == "ISS") begin
      if (rdy) begin
        model_clear_operands();
        m_mode = "A";
      end
      return;
    end
    if (!v) return;
    if (k == 15) begin
      model_clear_operands();
      m_op = 0; m_mode = "A";
    end else if (k <= 9) begin
      if (m_mode == "A" && a_cnt < 2) begin
        a_val = (a_val % 10) * 10 + k; a_cnt++;
      end else if (m_mode == "OP") begin
        b_val = k; b_cnt = 1; m_mode = "B";
      end else if (m_mode == "B" && b_cnt < 2) begin
        b_val = (b_val % 10) * 10 + k; b_cnt++;
      end
    end else if (k <= 13) begin
      if (m_mode == "A" && a_cnt >= 1) begin
        m_op = k - 10; b_val = 0; b_cnt = 0; m_mode = "OP";
      end else if (m_mode == "OP") begin
        m_op = k - 10;
      end
    end else if (m_mode == "B") begin
      if (m_op == 3 && b_val == 0) begin
        m_err = 1'b1; model_clear_operands(); m_mode = "A";
      end else begin
        m_oa = a_val; m_ob = b_val; m_mode = "ISS";
      end
    end
  endtask

  task automatic check_outputs();
    bit show_b;
    show_b = (m_mode == "B") || (m_mode == "ISS");
    chk("key_ready", {7'd0, bus.key_ready}, (m_mode != "ISS") ? 8'd1 : 8'd0);
    chk("out_valid", {7'd0, bus.out_valid}, (m_mode == "ISS") ? 8'd1 : 8'd0);
    chk("err", {7'd0, bus.err}, {7'd0, m_err});
    chk("disp_tens", {4'd0, bus.disp_tens}, 8'((show_b ? b_val : a_val) / 10));
    chk("disp_ones", {4'd0, bus.disp_ones}, 8'((show_b ? b_val : a_val) % 10));
    chk("op_a", bus.op_a, 8'(m_oa));
    chk("op_b", bus.op_b, 8'(m_ob));
    chk("op_code", {6'd0, bus.op_code}, 8'(m_op));
  endtask

  task automatic step(input bit v, input logic [3:0] k, input bit rd, input bit r);
    @(negedge clk);
    rst           = r;
    bus.key_valid = v;
    bus.key_code  = k;
    bus.out_ready = rd;
    @(posedge clk);
    model_edge(v, int'(k), rd, r);
    #1;
    check_outputs();
  endtask

  task automatic key(input logic [3:0] k);
    step(1'b1, k, g_rdy, 1'b0);
  endtask

  task automatic idle();
    step(1'b0, 4'd0, g_rdy, 1'b0);
  endtask

  initial begin
    rst           = 1'b1;
    bus.key_valid = 1'b0;
    bus.key_code  = 4'd0;
    bus.out_ready = 1'b0;
    m_mode        = "A";

    step(1'b1, 4'd3, 1'b0, 1'b1);
    step(1'b0, 4'd0, 1'b0, 1'b1);

    // 12 + 23 with the arithmetic stage stalling for three cycles
    g_rdy = 1'b0;
    key(4'd1); key(4'd2); key(4'd10); key(4'd2); key(4'd3); key(4'd14);
    idle(); idle(); idle();
    g_rdy = 1'b1;
    idle(); idle();

    key(4'd7); key(4'd12); key(4'd8); key(4'd14); idle();

    key(4'd4); key(4'd5); key(4'd6); key(4'd15);

    key(4'd9); key(4'd13); key(4'd0); key(4'd14); idle();

    key(4'd3); key(4'd10); key(4'd11); key(4'd5); key(4'd14); idle();
    key(4'd1); key(4'd10); key(4'd15); key(4'd14); idle();

    // operator and '=' with no digits yet, then divide by "00"
    key(4'd10); key(4'd14); key(4'd8); key(4'd15);
    key(4'd5); key(4'd13); key(4'd0); key(4'd0); key(4'd14); idle();

    // keys during ISSUE are ignored; reset overrides a pending request
    g_rdy = 1'b0;
    key(4'd2); key(4'd10); key(4'd3); key(4'd14);
    key(4'd5); key(4'd15);
    step(1'b1, 4'd14, 1'b1, 1'b1);
    idle();
    g_rdy = 1'b1;

    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 3) != 0, 4'($urandom_range(0, 15)),
           $urandom_range(0, 1) == 1, $urandom_range(0, 63) == 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
